// File: rtl/tt_proj_sel_ctrl.sv
// Chip-level project selector: pad-driven address counter, one-hot enable, guarded switch, output mux.
// Address events land 3 clk edges after the pad edge; outputs register 1 cycle after ow_all; no backpressure.
module tt_proj_sel_ctrl #(
  parameter int NUM_PROJ     = 6,
  parameter int ADDR_W       = 3,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel_rst_n,
  input  logic                   sel_inc,
  input  logic                   pad_clk,
  input  logic                   pad_rst_n,
  input  logic [7:0]             pad_ui_in,
  input  logic [7:0]             pad_uio_in,
  input  logic [NUM_PROJ*24-1:0] ow_all,
  output logic [17:0]            iw,
  output logic [NUM_PROJ-1:0]    ena,
  output logic [7:0]             pad_uo_out,
  output logic [7:0]             pad_uio_out,
  output logic [7:0]             pad_uio_oe,
  output logic [ADDR_W-1:0]      cur_addr,
  output logic                   running
);

  typedef enum logic {ST_SWITCH = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [7:0] GUARD_INIT = 8'(GUARD_CYCLES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          guard_q, guard_d;
  logic                rst_s1, rst_s2;
  logic                inc_s1, inc_s2, inc_s3;
  logic                inc_pulse;
  logic                running_r;
  logic [NUM_PROJ-1:0] ena_d;
  logic [23:0]         sel_ow, ow_d;

  // The clear synchronizer resets to its inactive level so a reset release does not
  // itself look like a pad clear and stretch the first guard window.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_s1 <= 1'b1;
      rst_s2 <= 1'b1;
      inc_s1 <= 1'b0;
      inc_s2 <= 1'b0;
      inc_s3 <= 1'b0;
    end else begin
      rst_s1 <= sel_rst_n;
      rst_s2 <= rst_s1;
      inc_s1 <= sel_inc;
      inc_s2 <= inc_s1;
      inc_s3 <= inc_s2;
    end
  end

  assign inc_pulse = inc_s2 & ~inc_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SWITCH;
      addr_q    <= '0;
      guard_q   <= GUARD_INIT;
      running_r <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      guard_q   <= guard_d;
      running_r <= running;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    guard_d = guard_q;
    if (!rst_s2) begin
      addr_d  = '0;
      state_d = ST_SWITCH;
      guard_d = GUARD_INIT;
    end else if (inc_pulse) begin
      addr_d  = addr_q + ADDR_W'(1);
      state_d = ST_SWITCH;
      guard_d = GUARD_INIT;
    end else if (state_q == ST_SWITCH) begin
      if (guard_q <= 8'd1) begin
        state_d = ST_RUN;
      end else begin
        guard_d = guard_q - 8'd1;
      end
    end
  end

  // Enable tracks the next state so it rises together with running.
  always_comb begin
    ena_d  = '0;
    sel_ow = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (state_d == ST_RUN && addr_d == ADDR_W'(k)) begin
        ena_d[k] = 1'b1;
      end
      if (addr_q == ADDR_W'(k)) begin
        sel_ow = ow_all[24*k +: 24];
      end
    end
    // Pads pass data only when both this and the next cycle are RUN, so the first
    // SWITCH cycle already shows zeros and addr_q is stable for the mux.
    ow_d = (state_q == ST_RUN && state_d == ST_RUN) ? sel_ow : 24'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ena         <= '0;
      pad_uio_oe  <= 8'h00;
      pad_uio_out <= 8'h00;
      pad_uo_out  <= 8'h00;
    end else begin
      ena         <= ena_d;
      pad_uio_oe  <= ow_d[23:16];
      pad_uio_out <= ow_d[15:8];
      pad_uo_out  <= ow_d[7:0];
    end
  end

  assign running  = (state_q == ST_RUN);
  assign cur_addr = addr_q;
  assign iw       = {pad_uio_in, pad_ui_in, pad_rst_n & running, pad_clk & running_r};

endmodule

// File: tb/tb_tt_proj_sel_ctrl.sv
// Bench for tt_proj_sel_ctrl: cycle-by-cycle compare against a behavioural model plus directed literal checks.
module tb_tt_proj_sel_ctrl;

  localparam int NUM_PROJ = 6;
  localparam int ADDR_W   = 3;
  localparam int GUARD    = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   sel_rst_n;
  logic                   sel_inc;
  logic                   pad_clk = 1'b0;
  logic                   pad_rst_n;
  logic [7:0]             pad_ui_in = 8'h00;
  logic [7:0]             pad_uio_in = 8'h00;
  logic [NUM_PROJ*24-1:0] ow_all;
  logic [17:0]            iw;
  logic [NUM_PROJ-1:0]    ena;
  logic [7:0]             pad_uo_out, pad_uio_out, pad_uio_oe;
  logic [ADDR_W-1:0]      cur_addr;
  logic                   running;

  int checks   = 0;
  int failures = 0;

  tt_proj_sel_ctrl #(.NUM_PROJ(NUM_PROJ), .ADDR_W(ADDR_W), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .rst(rst), .sel_rst_n(sel_rst_n), .sel_inc(sel_inc),
    .pad_clk(pad_clk), .pad_rst_n(pad_rst_n), .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in),
    .ow_all(ow_all), .iw(iw), .ena(ena), .pad_uo_out(pad_uo_out), .pad_uio_out(pad_uio_out),
    .pad_uio_oe(pad_uio_oe), .cur_addr(cur_addr), .running(running)
  );

  always #5 clk = ~clk;

  // Free-running project clock and data pads, changing between clk edges.
  always @(posedge clk) begin
    #3;
    pad_clk    = ~pad_clk;
    pad_ui_in  = 8'($urandom);
    pad_uio_in = 8'($urandom);
  end

  // Model: pad samples per edge, cycles since the last address event, RUN once that reaches GUARD.
  logic [2:0]  inc_h;
  logic [1:0]  rstn_h;
  int          m_addr = 0;
  int          since = 0;
  logic        m_run = 1'b0, m_run_r = 1'b0, run_before, pulse, rclr;
  logic [23:0] m_pads = 24'h0;
  logic [NUM_PROJ-1:0] m_ena;
  logic [17:0] exp_iw;
  logic        mdl_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      inc_h     = 3'b000;
      rstn_h    = 2'b11;
      m_addr    = 0;
      since     = 0;
      m_run     = 1'b0;
      m_run_r   = 1'b0;
      m_pads    = 24'h0;
      mdl_valid = 1'b1;
    end else begin
      pulse      = inc_h[1] & ~inc_h[2];
      rclr       = ~rstn_h[1];
      run_before = m_run;
      m_run_r    = m_run;
      if (rclr) begin
        m_addr = 0;
        since  = 0;
      end else if (pulse) begin
        m_addr = (m_addr + 1) % (1 << ADDR_W);
        since  = 0;
      end else if (since < GUARD) begin
        since++;
      end
      m_run  = (since >= GUARD);
      m_pads = (run_before && m_run && m_addr < NUM_PROJ) ? ow_all[24*m_addr +: 24] : 24'h0;
      inc_h  = {inc_h[1:0], sel_inc};
      rstn_h = {rstn_h[0], sel_rst_n};
    end
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      m_ena  = (m_run && m_addr < NUM_PROJ) ? NUM_PROJ'(1 << m_addr) : '0;
      exp_iw = {pad_uio_in, pad_ui_in, pad_rst_n & m_run, pad_clk & m_run_r};
      checks++;
      if (ena !== m_ena || running !== m_run || cur_addr !== ADDR_W'(m_addr) ||
          {pad_uio_oe, pad_uio_out, pad_uo_out} !== m_pads || iw !== exp_iw) begin
        failures++;
        $display("FAIL cycle_model t=%0t got ena=%b run=%b addr=%0d pads=%h iw=%h want ena=%b run=%b addr=%0d pads=%h iw=%h",
                 $time, ena, running, cur_addr, {pad_uio_oe, pad_uio_out, pad_uo_out}, iw,
                 m_ena, m_run, m_addr, m_pads, exp_iw);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic inc_once();
    sel_inc = 1'b1;
    cyc(3);
    sel_inc = 1'b0;
    cyc(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    sel_rst_n = 1'b1;
    sel_inc   = 1'b0;
    pad_rst_n = 1'b1;
    ow_all    = {24'h665544, 24'h554433, 24'h443322, 24'h332211, 24'hA53CF0, 24'h112233};
    cyc(3);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_ena", 32'(ena), 32'h0);
    chk("reset_pads", 32'({pad_uio_oe, pad_uio_out, pad_uo_out}), 32'h0);
    rst = 1'b0;

    // Guard after reset: four SWITCH cycles, then project 0.
    cyc(3);
    chk("guard_after_reset", 32'(running), 32'h0);
    cyc(1);
    chk("run_after_reset", 32'(running), 32'h1);
    chk("ena_after_reset", 32'(ena), 32'h01);
    pad_rst_n = 1'b0;
    #1;
    chk("iw1_low", 32'(iw[1]), 32'h0);
    pad_rst_n = 1'b1;
    #1;
    chk("iw1_high", 32'(iw[1]), 32'h1);

    // Single increment to project 1.
    sel_inc = 1'b1;
    cyc(3);
    chk("inc_addr", 32'(cur_addr), 32'h1);
    chk("inc_ena_off", 32'(ena), 32'h0);
    chk("inc_iw1_off", 32'(iw[1]), 32'h0);
    sel_inc = 1'b0;
    cyc(3);
    chk("inc_still_guard", 32'(ena), 32'h0);
    cyc(1);
    chk("inc_ena1", 32'(ena), 32'h02);
    cyc(1);
    chk("pad_uio_oe", 32'(pad_uio_oe), 32'hA5);
    chk("pad_uio_out", 32'(pad_uio_out), 32'h3C);
    chk("pad_uo_out", 32'(pad_uo_out), 32'hF0);

    // Clear, then walk through invalid addresses and wrap.
    sel_rst_n = 1'b0;
    cyc(4);
    sel_rst_n = 1'b1;
    cyc(8);
    for (int i = 1; i <= 8; i++) begin
      inc_once();
      cyc(4);
      if (i == 6 || i == 7) begin
        chk("invalid_running", 32'(running), 32'h1);
        chk("invalid_ena", 32'(ena), 32'h0);
        chk("invalid_pads", 32'({pad_uio_oe, pad_uio_out, pad_uo_out}), 32'h0);
        chk("invalid_addr", 32'(cur_addr), 32'(i));
      end
    end
    chk("wrap_addr", 32'(cur_addr), 32'h0);
    chk("wrap_ena", 32'(ena), 32'h01);

    // A long-held sel_inc counts once.
    sel_inc = 1'b1;
    cyc(12);
    chk("held_inc", 32'(cur_addr), 32'h1);
    sel_inc = 1'b0;
    cyc(6);

    // Clear wins over a simultaneous increment at address 3.
    inc_once();
    cyc(4);
    inc_once();
    cyc(4);
    chk("prio_start", 32'(cur_addr), 32'h3);
    sel_inc   = 1'b1;
    sel_rst_n = 1'b0;
    cyc(1);
    sel_inc = 1'b0;
    cyc(6);
    chk("prio_addr", 32'(cur_addr), 32'h0);
    chk("prio_hold", 32'(running), 32'h0);
    sel_rst_n = 1'b1;
    cyc(5);
    chk("prio_guard", 32'(running), 32'h0);
    cyc(1);
    chk("prio_run", 32'(running), 32'h1);
    chk("prio_ena", 32'(ena), 32'h01);

    // Second edge two cycles into SWITCH reloads the guard.
    cyc(2);
    sel_inc = 1'b1;
    cyc(1);
    sel_inc = 1'b0;
    cyc(1);
    sel_inc = 1'b1;
    cyc(1);
    sel_inc = 1'b0;
    chk("reload_first", 32'(cur_addr), 32'h1);
    cyc(2);
    chk("reload_second", 32'(cur_addr), 32'h2);
    cyc(3);
    chk("reload_guard", 32'(running), 32'h0);
    cyc(1);
    chk("reload_run", 32'(running), 32'h1);
    chk("reload_ena", 32'(ena), 32'h04);
    cyc(4);

    // Reset in the middle of RUN.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_addr", 32'(cur_addr), 32'h0);
    chk("midrst_ena", 32'(ena), 32'h0);
    chk("midrst_running", 32'(running), 32'h0);
    cyc(3);
    chk("midrst_guard", 32'(running), 32'h0);
    cyc(1);
    chk("midrst_ena0", 32'(ena), 32'h01);
    ow_all[23:0] = 24'h123456;
    cyc(1);
    chk("latency_uo", 32'(pad_uo_out), 32'h56);
    chk("latency_oe", 32'(pad_uio_oe), 32'h12);
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
